// File: rtl/data_mem_port_if.sv
// Request/response bus between a load/store unit and data_mem_port.
interface data_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_port.sv
// Byte-addressable little-endian data memory port; misaligned accesses are
// either split into two word beats or rejected, depending on MISALIGN_SPLIT.
module data_mem_port #(
  parameter int unsigned ADDR_BITS      = 8,
  parameter bit          MISALIGN_SPLIT = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_port_if.slave bus
);
  localparam int unsigned IW    = ADDR_BITS - 2;
  localparam int unsigned WORDS = 2 ** IW;

  typedef enum logic {S_IDLE, S_SECOND} state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]   r_mem [WORDS];
  logic [1:0]    r_off;
  logic [1:0]    r_size;
  logic          r_uns;
  logic          r_write;
  logic [IW-1:0] r_idx_hi;
  logic [3:0]    r_mask_hi;
  logic [31:0]   r_wdata_hi;
  logic [31:0]   r_lo;

  logic          w_accept, w_misal, w_err, w_split, w_oob, w_second;
  logic [2:0]    w_nbytes;
  logic [32:0]   w_last;
  logic [1:0]    w_off;
  logic [7:0]    w_szmask, w_bmask;
  logic [63:0]   w_wide, w_cat;
  logic [IW-1:0] w_idx, w_widx;
  logic [31:0]   w_rword, w_raw1, w_raw2, w_ext1, w_ext2, w_wdata;
  logic          w_we;
  logic [3:0]    w_wmask;

  function automatic logic [31:0] f_extend(input logic [31:0] raw,
                                           input logic [1:0]  size,
                                           input logic        uns);
    case (size)
      2'd0:    f_extend = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
      2'd1:    f_extend = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: f_extend = raw;
    endcase
  endfunction

  assign w_second      = (r_state == S_SECOND);
  assign bus.req_ready = (r_state == S_IDLE);
  assign w_accept      = bus.req_valid && bus.req_ready && !reset;
  assign w_off         = bus.req_addr[1:0];
  assign w_idx         = bus.req_addr[ADDR_BITS-1:2];

  always_comb begin
    w_nbytes = 3'd0;
    w_szmask = 8'h00;
    case (bus.req_size)
      2'd0:    begin w_nbytes = 3'd1; w_szmask = 8'h01; end
      2'd1:    begin w_nbytes = 3'd2; w_szmask = 8'h03; end
      2'd2:    begin w_nbytes = 3'd4; w_szmask = 8'h0F; end
      default: begin w_nbytes = 3'd0; w_szmask = 8'h00; end
    endcase
  end

  // Last byte must fit below 2^ADDR_BITS; this also catches nonzero upper address bits.
  assign w_last  = {1'b0, bus.req_addr} + 33'(w_nbytes) - 33'd1;
  assign w_oob   = (w_last >> ADDR_BITS) != '0;
  assign w_misal = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                   ((bus.req_size == 2'd2) && (w_off != 2'd0));
  assign w_err   = (bus.req_size == 2'd3) || w_oob || (w_misal && !MISALIGN_SPLIT);
  assign w_split = w_misal && !w_err;

  // Byte lanes and data spread across two adjacent words; upper half is beat 2.
  assign w_bmask = w_szmask << w_off;
  assign w_wide  = {32'd0, bus.req_wdata} << {w_off, 3'b000};

  assign w_rword = r_mem[w_second ? r_idx_hi : w_idx];
  assign w_raw1  = w_rword >> {w_off, 3'b000};
  assign w_ext1  = f_extend(w_raw1, bus.req_size, bus.req_unsigned);
  assign w_cat   = {w_rword, r_lo};
  assign w_raw2  = w_cat[{r_off, 3'b000} +: 32];
  assign w_ext2  = f_extend(w_raw2, r_size, r_uns);

  assign w_we    = w_second ? (r_write && !reset)
                            : (w_accept && !w_err && bus.req_write);
  assign w_widx  = w_second ? r_idx_hi   : w_idx;
  assign w_wmask = w_second ? r_mask_hi  : w_bmask[3:0];
  assign w_wdata = w_second ? r_wdata_hi : w_wide[31:0];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (w_we && w_wmask[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && w_split) w_state_nxt = S_SECOND;
      S_SECOND: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_off      <= w_off;
      r_size     <= bus.req_size;
      r_uns      <= bus.req_unsigned;
      r_write    <= bus.req_write;
      r_idx_hi   <= w_idx + 1'b1;
      r_mask_hi  <= w_bmask[7:4];
      r_wdata_hi <= w_wide[63:32];
      r_lo       <= w_rword;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      if (w_second) begin
        bus.resp_valid <= 1'b1;
        bus.resp_rdata <= r_write ? '0 : w_ext2;
      end else if (w_accept) begin
        if (w_err) begin
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b1;
        end else if (!w_split) begin
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= bus.req_write ? '0 : w_ext1;
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem_port.sv
// Randomized bench for data_mem_port: DUT 0 splits misaligned accesses,
// DUT 1 rejects them; both are checked against a byte-array reference model.
module tb_data_mem_port;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] mdl [2][256];

  data_mem_port_if bus0 ();
  data_mem_port_if bus1 ();

  data_mem_port #(.ADDR_BITS(8), .MISALIGN_SPLIT(1'b1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  data_mem_port #(.ADDR_BITS(8), .MISALIGN_SPLIT(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    bus0.req_write = wr;   bus1.req_write = wr;
    bus0.req_size = sz;    bus1.req_size = sz;
    bus0.req_unsigned = uns; bus1.req_unsigned = uns;
    bus0.req_addr = addr;  bus1.req_addr = addr;
    bus0.req_wdata = wd;   bus1.req_wdata = wd;
    bus0.req_valid = v && (sel == 0);
    bus1.req_valid = v && (sel == 1);
  endtask

  function automatic logic rd_ready(input int sel);
    return (sel == 1) ? bus1.req_ready : bus0.req_ready;
  endfunction
  function automatic logic rd_valid(input int sel);
    return (sel == 1) ? bus1.resp_valid : bus0.resp_valid;
  endfunction
  function automatic logic rd_err(input int sel);
    return (sel == 1) ? bus1.resp_err : bus0.resp_err;
  endfunction
  function automatic logic [31:0] rd_data(input int sel);
    return (sel == 1) ? bus1.resp_rdata : bus0.resp_rdata;
  endfunction

  // One request, predicted from byte-level rules; returns what the DUT answered.
  task automatic do_req(input int sel, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] got_d, output logic got_e);
    int nb;
    longint last;
    bit mis, err, two;
    logic [31:0] exp_d;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    last = longint'(addr) + nb - 1;
    mis  = (nb == 2 && addr % 2 != 0) || (nb == 4 && addr % 4 != 0);
    err  = (nb == 0) || (last > 255) || (mis && sel == 1);
    two  = mis && !err;
    exp_d = '0;
    if (!err && !wr) begin
      for (int i = 0; i < nb; i++) exp_d[8*i +: 8] = mdl[sel][int'(addr) + i];
      if (!uns && nb < 4 && exp_d[8*nb-1])
        for (int i = nb; i < 4; i++) exp_d[8*i +: 8] = 8'hFF;
    end
    if (!err && wr)
      for (int i = 0; i < nb; i++) mdl[sel][int'(addr) + i] = wd[8*i +: 8];

    drive(sel, 1'b1, wr, sz, uns, addr, wd);
    chk("ready_at_req", 32'(rd_ready(sel)), 32'd1);
    @(posedge clk); #1;
    drive(sel, 1'b0, wr, sz, uns, addr, wd);
    if (two) begin
      chk("ready_second", 32'(rd_ready(sel)), 32'd0);
      chk("valid_second", 32'(rd_valid(sel)), 32'd0);
      // Scrambled fields with valid held must be ignored while busy.
      drive(sel, 1'b1, $urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
            $urandom_range(0, 255), $urandom);
      @(posedge clk); #1;
      drive(sel, 1'b0, wr, sz, uns, addr, wd);
    end
    got_d = rd_data(sel);
    got_e = rd_err(sel);
    chk("resp_valid", 32'(rd_valid(sel)), 32'd1);
    chk("resp_err", 32'(got_e), 32'(err));
    chk("resp_rdata", got_d, exp_d);
  endtask

  initial begin
    logic [31:0] d;
    logic e;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid0", 32'(bus0.resp_valid), 32'd0);
    chk("rst_rdata0", bus0.resp_rdata, 32'd0);
    chk("rst_err1", 32'(bus1.resp_err), 32'd0);
    chk("rst_ready0", 32'(bus0.req_ready), 32'd1);

    for (int w = 0; w < 64; w++) begin
      do_req(0, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, d, e);
      do_req(1, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, d, e);
    end

    // Sign/zero extension of a high byte.
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h8765_4321, d, e);
    do_req(0, 1'b0, 2'd0, 1'b0, 32'h13, '0, d, e);
    chk("byte_signed", d, 32'hFFFF_FF87);
    do_req(0, 1'b0, 2'd0, 1'b1, 32'h13, '0, d, e);
    chk("byte_unsigned", d, 32'h0000_0087);

    // Split store across the 0x0F/0x10 boundary.
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h0E, 32'hAABB_CCDD, d, e);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h0C, '0, d, e);
    chk("split_word_hi", d >> 16, 32'h0000_CCDD);
    do_req(0, 1'b0, 2'd1, 1'b0, 32'h10, '0, d, e);
    chk("split_half", d, 32'hFFFF_AABB);

    // Rejecting variant and illegal size.
    do_req(1, 1'b0, 2'd2, 1'b0, 32'h01, '0, d, e);
    chk("nosplit_err", 32'(e), 32'd1);
    chk("nosplit_data", d, 32'd0);
    do_req(1, 1'b0, 2'd3, 1'b0, 32'h00, '0, d, e);
    chk("size3_err", 32'(e), 32'd1);

    // Range boundaries.
    do_req(0, 1'b0, 2'd2, 1'b0, 32'hFC, '0, d, e);
    chk("top_word_ok", 32'(e), 32'd0);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'hFD, '0, d, e);
    chk("top_word_oob", 32'(e), 32'd1);
    do_req(0, 1'b0, 2'd0, 1'b0, 32'h100, '0, d, e);
    chk("byte_oob", 32'(e), 32'd1);
    do_req(0, 1'b1, 2'd0, 1'b0, 32'h8000_0020, 32'h11, d, e);

    // Store then immediate load of the same byte.
    do_req(0, 1'b1, 2'd0, 1'b0, 32'h20, 32'h5A, d, e);
    do_req(0, 1'b0, 2'd0, 1'b1, 32'h20, '0, d, e);
    chk("st_ld_fwd", d, 32'h0000_005A);

    // Reset during beat 2: only beat-1 bytes land, no response.
    drive(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h22, 32'h1234_5678);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h22, 32'h1234_5678);
    chk("rst2_ready", 32'(bus0.req_ready), 32'd0);
    mdl[0][8'h22] = 8'h78;
    mdl[0][8'h23] = 8'h56;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst2_no_resp", 32'(bus0.resp_valid), 32'd0);
    chk("rst2_ready1", 32'(bus0.req_ready), 32'd1);
    do_req(0, 1'b0, 2'd1, 1'b1, 32'h22, '0, d, e);
    chk("rst2_beat1", d, 32'h0000_5678);
    do_req(0, 1'b0, 2'd1, 1'b1, 32'h24, '0, d, e);

    // Request during reset is dropped.
    reset = 1'b1;
    drive(0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h30, {24'd0, ~mdl[0][8'h30]});
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
    @(posedge clk); #1;
    chk("rstreq_no_resp", 32'(bus0.resp_valid), 32'd0);
    do_req(0, 1'b0, 2'd0, 1'b1, 32'h30, '0, d, e);

    // Back-to-back aligned loads, one per cycle.
    begin
      int unsigned t0;
      t0 = $time;
      for (int i = 0; i < 10; i++)
        do_req(0, 1'b0, 2'd2, 1'b0, 32'($urandom_range(0, 63) * 4), '0, d, e);
      chk("b2b_cycles", 32'(($time - t0) / 10), 32'd10);
    end

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 259));
      do_req($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
             $urandom_range(0, 1), a, $urandom, d, e);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
